// File: rtl/pwm_peripheral.sv
// 16-pin PWM output stage driven by the SPI register file enables and one shared duty byte.
// Duty is shadowed at each period boundary; all pin outputs are registered.
module pwm_peripheral #(
    parameter int unsigned PRESCALE = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic [7:0]       per_cnt;
    logic [7:0]       duty_sh;
    logic [7:0]       duty_eff;
    logic             tick;
    logic             load;
    logic             pwm_lvl;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;
    logic [15:0]      out_nxt;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        en_out   = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        tick     = (pre_cnt == PRE_MAX);
        load     = (pre_cnt == '0) && (per_cnt == 8'h00);
        // Bypass the shadow at the boundary so a new duty shows on the very first clk.
        duty_eff = load ? pwm_duty_cycle : duty_sh;
        pwm_lvl  = (duty_eff == 8'hFF) || (per_cnt < duty_eff);
        out_nxt  = en_out & (~en_pwm | {16{pwm_lvl}});
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt      <= '0;
            per_cnt      <= 8'h00;
            duty_sh      <= 8'h00;
            out          <= 16'h0000;
            period_start <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                per_cnt <= per_cnt + 8'd1;
            end
            if (load) begin
                duty_sh <= pwm_duty_cycle;
            end
            out          <= out_nxt;
            period_start <= load;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral at PRESCALE=2: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares out/period_start.
module tb_pwm_peripheral;

    localparam int PRESCALE = 2;
    localparam int PERIOD   = 256 * PRESCALE;

    typedef struct packed {
        logic [15:0] out;
        logic        ps;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        period_start;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   phase;
    int   cyc;
    logic [7:0] duty_act;

    always #5 clk = ~clk;

    pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_out[7:0]),
        .en_reg_out_15_8 (en_out[15:8]),
        .en_reg_pwm_7_0  (en_pwm[7:0]),
        .en_reg_pwm_15_8 (en_pwm[15:8]),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (period_start)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected pin level for this clk, from the period phase (clk index within the period).
    task automatic step();
        exp_t e;
        logic lvl;
        if (phase == 0) duty_act = duty;
        lvl  = (duty_act == 8'hFF) || (phase < int'(duty_act) * PRESCALE);
        e.out = en_out & (~en_pwm | {16{lvl}});
        e.ps  = (phase == 0);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
        phase = (phase + 1) % PERIOD;
        cyc++;
    endtask

    task automatic run_to_boundary();
        while (phase != 0) step();
    endtask

    // Monitor: one popped expectation per clk the stimulus advanced.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("out", {16'h0, out}, {16'h0, e.out});
                check("period_start", {31'h0, period_start}, {31'h0, e.ps});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int hi3, hi7, hi15;
        int last_ps;

        rst = 1'b1; en_out = 16'h0; en_pwm = 16'h0; duty = 8'h00;
        phase = 0; cyc = 0; duty_act = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out", {16'h0, out}, 32'h0);
        check("reset_ps", {31'h0, period_start}, 32'h0);

        // Reset mid high phase, asynchronously
        #1; rst = 1'b0; phase = 0;
        en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
        repeat (100) step();
        check("pre_reset_high", {16'h0, out}, 32'h0000_FFFF);
        rst = 1'b1;
        #1;
        check("async_reset_out", {16'h0, out}, 32'h0);
        check("async_reset_ps", {31'h0, period_start}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1; rst = 1'b0; phase = 0;

        // Static pins, enables take effect one clk later
        en_out = 16'h0001; en_pwm = 16'h0000; duty = 8'h5A;
        repeat (10) step();
        en_out = 16'h8001;
        repeat (10) step();

        // 50 % PWM and period_start spacing
        en_out = 16'hFFFF; en_pwm = 16'hFFFF; duty = 8'h80;
        run_to_boundary();
        last_ps = -1;
        repeat (2 * PERIOD + 1) begin
            step();
            if (period_start) begin
                if (last_ps >= 0) check("ps_gap", cyc - last_ps, PERIOD);
                last_ps = cyc;
            end
        end

        // Extremes
        duty = 8'h00;
        run_to_boundary();
        repeat (3 * PERIOD) step();
        duty = 8'hFF;
        run_to_boundary();
        hi = 0;
        repeat (3 * PERIOD) begin
            step();
            if (out == 16'hFFFF) hi++;
        end
        check("ff_never_low", hi, 3 * PERIOD);

        // Shadowing: mid-period write waits for the next boundary
        duty = 8'h40;
        run_to_boundary();
        hi = 0;
        repeat (32) begin
            step();
            if (out[0]) hi++;
        end
        duty = 8'hC0;
        repeat (PERIOD - 32) begin
            step();
            if (out[0]) hi++;
        end
        check("shadow_cur_high", hi, 128);
        hi = 0;
        repeat (PERIOD) begin
            step();
            if (out[0]) hi++;
        end
        check("shadow_next_high", hi, 384);

        // Mixed gating
        en_out = 16'h00FF; en_pwm = 16'hF00F; duty = 8'h20;
        run_to_boundary();
        step();
        repeat (PERIOD - 1) step();
        hi3 = 0; hi7 = 0; hi15 = 0;
        repeat (PERIOD) begin
            step();
            if (out[3])  hi3++;
            if (out[7])  hi7++;
            if (out[15]) hi15++;
        end
        check("mixed_bit3_high", hi3, 64);
        check("mixed_bit7_high", hi7, PERIOD);
        check("mixed_bit15_high", hi15, 0);

        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
